cp0_except_commit: RTL
======================

CP0_EXCEPT_COMMIT -- requirements
Module: cp0_except_commit

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous reset, active-high.
REQ-002 SHALL have exc_flush in 1 (exception/eret commit from MEM stage), exc_eret in 1, exc_code in 5, exc_cur_pc in 32, exc_extra in 32, exc_delayslot in 1.
REQ-003 SHALL have cp0_we in 1, cp0_waddr in 5, cp0_wsel in 3, cp0_wdata in 32 (MTC0 write port).
REQ-004 SHALL have cp0_raddr in 5, cp0_rsel in 3, cp0_rdata out 32 (MFC0 read port, combinational).
REQ-005 SHALL have hw_int in 6 (external interrupt lines, level).
REQ-006 SHALL have status, cause, epc, ebase, error_epc, badvaddr, entryhi, count, compare out 32 each; interrupt_flag out 8; timer_int out 1.

Function
REQ-007 Register map (addr/sel): BadVAddr 8/0, Count 9/0, EntryHi 10/0, Compare 11/0, Status 12/0, Cause 13/0, EPC 14/0, PRId 15/0 (const 0x0001_8000), EBase 15/1, ErrorEPC 30/0; others read 0, writes ignored.
REQ-008 Status writable bits: CU0[28], BEV[22], IM[15:8], ERL[2], EXL[1], IE[0]; others read 0.
REQ-009 Cause writable bits: IV[23], IP[1:0] (bits 9:8) only; ExcCode[6:2], BD[31], TI[30], CE[29:28], IP[7:2] hardware-owned.
REQ-010 EBase writable [29:12]; [31:30] fixed 2'b10; [11:0] read 0.
REQ-011 EntryHi writable [31:13],[7:0]; BadVAddr read-only to MTC0.
REQ-012 Cause.IP[7:2] SHALL register {hw_int[5] | TI, hw_int[4:0]} every cycle (1-cycle latency).
REQ-013 interrupt_flag SHALL equal Cause.IP[7:0] & Status.IM[7:0], combinational from registers.
REQ-014 Count SHALL increment by 1 every second cycle via internal toggle bit; wraps 0xFFFF_FFFF -> 0.
REQ-015 MTC0 to Count SHALL load cp0_wdata and clear the toggle bit; increment suppressed that cycle.
REQ-016 TI SHALL set at the edge where registered count == compare; MTC0 to Compare SHALL clear TI and wins over a same-cycle set.
REQ-017 timer_int SHALL equal Cause.TI.
REQ-018 Exception commit (exc_flush=1, exc_eret=0): Status.EXL<=1; Cause.ExcCode<=exc_code.
REQ-019 On commit with Status.EXL=0: EPC<=exc_delayslot ? exc_cur_pc-4 : exc_cur_pc; Cause.BD<=exc_delayslot. With EXL=1: EPC and BD unchanged.
REQ-020 On commit with exc_code in {1 Mod, 2 TLBL, 3 TLBS, 4 AdEL, 5 AdES}: BadVAddr<=exc_extra; for codes 1-3 also EntryHi[31:13]<=exc_extra[31:13].
REQ-021 On commit with exc_code=11 (CpU): Cause.CE<=exc_extra[1:0]; otherwise CE unchanged.
REQ-022 ERET (exc_flush=1, exc_eret=1): if Status.ERL=1 then ERL<=0 else EXL<=0; no other register changes.
REQ-023 When exc_flush=1 the same-cycle MTC0 SHALL be discarded entirely; Count increment and IP/TI sampling proceed.
REQ-024 cp0_rdata SHALL bypass: if cp0_we=1, exc_flush=0 and write addr/sel match read addr/sel, return write data merged through the writable mask; else the register value.
REQ-025 exc_flush=0 SHALL leave all exception-owned fields unchanged regardless of other exc_* inputs.

Reset
REQ-026 On rst=1 at a clock edge: Status=0x0040_0004 (BEV=1, ERL=1), Cause=0, EPC=0, ErrorEPC=0, BadVAddr=0, EntryHi=0, Count=0, toggle=0, Compare=0, EBase=0x8000_0000.
REQ-027 rst SHALL override same-cycle exc_flush and MTC0; interrupt_flag=0 and timer_int=0 the cycle after reset.

Verification
REQ-028 Reset, then MTC0 Status=0xFFFF_FFFF -> read Status=0x1040_FF07.
REQ-029 EXL=0, exc_flush, code=4, cur_pc=0xBFC0_0104, delayslot=1, extra=0x1234_5679 -> EPC=0xBFC0_0100, BD=1, ExcCode=4, BadVAddr=0x1234_5679, EXL=1.
REQ-030 EXL=1, second commit code=12, cur_pc=0x8000_0200 -> EPC unchanged, ExcCode=12; then ERET with ERL=0 -> EXL=0.
REQ-031 Count=0x10 loaded, Compare=0x12 -> TI set after 4-5 cycles, timer_int=1, IP7=1 next cycle; MTC0 Compare -> TI=0.
REQ-032 IM=0x04, hw_int=6'b000001 -> interrupt_flag=0x04 two cycles after assertion; IM=0 -> 0x00.
REQ-033 Same-cycle exc_flush and MTC0 EPC=0xDEAD_BEEF -> EPC holds commit value; cp0_rdata bypass not applied.

Source files
------------

// File: rtl/cp0_except_commit.sv
// CP0 register file with exception/ERET commit, MTC0/MFC0 access,
// Count/Compare timer and interrupt pending/mask logic.
module cp0_except_commit (
    input  logic        clk,
    input  logic        rst,
    input  logic        exc_flush,
    input  logic        exc_eret,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_cur_pc,
    input  logic [31:0] exc_extra,
    input  logic        exc_delayslot,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [2:0]  cp0_wsel,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    input  logic [2:0]  cp0_rsel,
    output logic [31:0] cp0_rdata,
    input  logic [5:0]  hw_int,
    output logic [31:0] status,
    output logic [31:0] cause,
    output logic [31:0] epc,
    output logic [31:0] ebase,
    output logic [31:0] error_epc,
    output logic [31:0] badvaddr,
    output logic [31:0] entryhi,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic [7:0]  interrupt_flag,
    output logic        timer_int
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned KEY_W = 8;

    // {addr, sel} register keys
    localparam logic [KEY_W-1:0] KEY_BADVADDR = {5'd8, 3'd0};
    localparam logic [KEY_W-1:0] KEY_COUNT    = {5'd9, 3'd0};
    localparam logic [KEY_W-1:0] KEY_ENTRYHI  = {5'd10, 3'd0};
    localparam logic [KEY_W-1:0] KEY_COMPARE  = {5'd11, 3'd0};
    localparam logic [KEY_W-1:0] KEY_STATUS   = {5'd12, 3'd0};
    localparam logic [KEY_W-1:0] KEY_CAUSE    = {5'd13, 3'd0};
    localparam logic [KEY_W-1:0] KEY_EPC      = {5'd14, 3'd0};
    localparam logic [KEY_W-1:0] KEY_PRID     = {5'd15, 3'd0};
    localparam logic [KEY_W-1:0] KEY_EBASE    = {5'd15, 3'd1};
    localparam logic [KEY_W-1:0] KEY_ERROREPC = {5'd30, 3'd0};

    localparam logic [XLEN-1:0] PRID_VAL     = 32'h0001_8000;
    localparam logic [XLEN-1:0] STATUS_RST   = 32'h0040_0004;
    localparam logic [XLEN-1:0] EBASE_RST    = 32'h8000_0000;

    localparam logic [XLEN-1:0] MASK_STATUS  = 32'h1040_FF07;
    localparam logic [XLEN-1:0] MASK_CAUSE   = 32'h0080_0300;
    localparam logic [XLEN-1:0] MASK_EBASE   = 32'h3FFF_F000;
    localparam logic [XLEN-1:0] MASK_ENTRYHI = 32'hFFFF_E0FF;
    localparam logic [XLEN-1:0] MASK_FULL    = 32'hFFFF_FFFF;

    localparam int unsigned ST_IE  = 0;
    localparam int unsigned ST_EXL = 1;
    localparam int unsigned ST_ERL = 2;
    localparam int unsigned CA_TI  = 30;
    localparam int unsigned CA_BD  = 31;

    localparam logic [4:0] EXC_MOD  = 5'd1;
    localparam logic [4:0] EXC_TLBS = 5'd3;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_CPU  = 5'd11;

    logic [XLEN-1:0] status_q,   status_d;
    logic [XLEN-1:0] cause_q,    cause_d;
    logic [XLEN-1:0] epc_q,      epc_d;
    logic [XLEN-1:0] ebase_q,    ebase_d;
    logic [XLEN-1:0] error_epc_q, error_epc_d;
    logic [XLEN-1:0] badvaddr_q, badvaddr_d;
    logic [XLEN-1:0] entryhi_q,  entryhi_d;
    logic [XLEN-1:0] count_q,    count_d;
    logic [XLEN-1:0] compare_q,  compare_d;
    logic            toggle_q,   toggle_d;

    logic [KEY_W-1:0] wr_key;
    logic [KEY_W-1:0] rd_key;
    logic             wr_en;
    logic [XLEN-1:0]  wr_mask;
    logic [XLEN-1:0]  rd_mask;
    logic [XLEN-1:0]  rd_val;

    // MTC0-writable bit mask for a register key; zero for read-only/unmapped
    function automatic logic [XLEN-1:0] wmask(input logic [KEY_W-1:0] key);
        logic [XLEN-1:0] m;
        m = '0;
        case (key)
            KEY_COUNT:    m = MASK_FULL;
            KEY_ENTRYHI:  m = MASK_ENTRYHI;
            KEY_COMPARE:  m = MASK_FULL;
            KEY_STATUS:   m = MASK_STATUS;
            KEY_CAUSE:    m = MASK_CAUSE;
            KEY_EPC:      m = MASK_FULL;
            KEY_EBASE:    m = MASK_EBASE;
            KEY_ERROREPC: m = MASK_FULL;
            default:      m = '0;
        endcase
        return m;
    endfunction

    assign wr_key  = {cp0_waddr, cp0_wsel};
    assign rd_key  = {cp0_raddr, cp0_rsel};
    assign wr_en   = cp0_we & ~exc_flush;
    assign wr_mask = wmask(wr_key);
    assign rd_mask = wmask(rd_key);

    // MFC0 read mux with same-cycle MTC0 bypass (suppressed on flush)
    always_comb begin
        rd_val = '0;
        case (rd_key)
            KEY_BADVADDR: rd_val = badvaddr_q;
            KEY_COUNT:    rd_val = count_q;
            KEY_ENTRYHI:  rd_val = entryhi_q;
            KEY_COMPARE:  rd_val = compare_q;
            KEY_STATUS:   rd_val = status_q;
            KEY_CAUSE:    rd_val = cause_q;
            KEY_EPC:      rd_val = epc_q;
            KEY_PRID:     rd_val = PRID_VAL;
            KEY_EBASE:    rd_val = ebase_q;
            KEY_ERROREPC: rd_val = error_epc_q;
            default:      rd_val = '0;
        endcase
        cp0_rdata = rd_val;
        if (wr_en && (wr_key == rd_key)) begin
            cp0_rdata = (rd_val & ~rd_mask) | (cp0_wdata & rd_mask);
        end
    end

    // Next-state: timer, interrupt sampling, MTC0 writes, exception/ERET commit
    always_comb begin
        status_d    = status_q;
        cause_d     = cause_q;
        epc_d       = epc_q;
        ebase_d     = ebase_q;
        error_epc_d = error_epc_q;
        badvaddr_d  = badvaddr_q;
        entryhi_d   = entryhi_q;
        count_d     = count_q + XLEN'(toggle_q);
        compare_d   = compare_q;
        toggle_d    = ~toggle_q;

        // hardware interrupt lines, IP7 shared with the timer
        cause_d[15:10] = {hw_int[5] | cause_q[CA_TI], hw_int[4:0]};

        // Compare write clears TI and takes priority over a match
        if (wr_en && (wr_key == KEY_COMPARE)) begin
            cause_d[CA_TI] = 1'b0;
        end else if (count_q == compare_q) begin
            cause_d[CA_TI] = 1'b1;
        end

        if (wr_en) begin
            case (wr_key)
                KEY_COUNT: begin
                    count_d  = cp0_wdata;
                    toggle_d = 1'b0;
                end
                KEY_COMPARE:  compare_d   = cp0_wdata;
                KEY_STATUS:   status_d    = (status_q & ~wr_mask) | (cp0_wdata & wr_mask);
                KEY_CAUSE:    cause_d     = (cause_d & ~wr_mask) | (cp0_wdata & wr_mask);
                KEY_EPC:      epc_d       = cp0_wdata;
                KEY_EBASE:    ebase_d     = (ebase_q & ~wr_mask) | (cp0_wdata & wr_mask);
                KEY_ERROREPC: error_epc_d = cp0_wdata;
                KEY_ENTRYHI:  entryhi_d   = (entryhi_q & ~wr_mask) | (cp0_wdata & wr_mask);
                default: ;
            endcase
        end

        if (exc_flush) begin
            if (exc_eret) begin
                if (status_q[ST_ERL]) begin
                    status_d[ST_ERL] = 1'b0;
                end else begin
                    status_d[ST_EXL] = 1'b0;
                end
            end else begin
                status_d[ST_EXL] = 1'b1;
                cause_d[6:2]     = exc_code;
                // nested exceptions keep the original return point
                if (!status_q[ST_EXL]) begin
                    epc_d          = exc_delayslot ? (exc_cur_pc - 32'd4) : exc_cur_pc;
                    cause_d[CA_BD] = exc_delayslot;
                end
                if ((exc_code >= EXC_MOD) && (exc_code <= EXC_ADES)) begin
                    badvaddr_d = exc_extra;
                end
                if ((exc_code >= EXC_MOD) && (exc_code <= EXC_TLBS)) begin
                    entryhi_d[31:13] = exc_extra[31:13];
                end
                if (exc_code == EXC_CPU) begin
                    cause_d[29:28] = exc_extra[1:0];
                end
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q    <= STATUS_RST;
            cause_q     <= '0;
            epc_q       <= '0;
            ebase_q     <= EBASE_RST;
            error_epc_q <= '0;
            badvaddr_q  <= '0;
            entryhi_q   <= '0;
            count_q     <= '0;
            compare_q   <= '0;
            toggle_q    <= 1'b0;
        end else begin
            status_q    <= status_d;
            cause_q     <= cause_d;
            epc_q       <= epc_d;
            ebase_q     <= ebase_d;
            error_epc_q <= error_epc_d;
            badvaddr_q  <= badvaddr_d;
            entryhi_q   <= entryhi_d;
            count_q     <= count_d;
            compare_q   <= compare_d;
            toggle_q    <= toggle_d;
        end
    end

    assign status         = status_q;
    assign cause          = cause_q;
    assign epc            = epc_q;
    assign ebase          = ebase_q;
    assign error_epc      = error_epc_q;
    assign badvaddr       = badvaddr_q;
    assign entryhi        = entryhi_q;
    assign count          = count_q;
    assign compare        = compare_q;
    assign interrupt_flag = cause_q[15:8] & status_q[15:8];
    assign timer_int      = cause_q[CA_TI];

    logic unused_ie;
    assign unused_ie = status_q[ST_IE];

endmodule
